// File: rtl/t04_pc_ras_unit_if.sv
// Bundle between the decoder/branch-compare side and the PC/RAS unit.
// The core side drives the jump controls; the unit returns fetch address, link value and check flags.
interface t04_pc_ras_unit_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    // enable is the only flow control: 1 accepts this cycle's controls, 0 stalls the unit.
    logic                         enable;
    logic [XLEN-1:0]              immJumpValue;
    logic [XLEN-1:0]              regJumpValue;
    logic                         doForceJump;
    logic                         doCondJump;
    logic                         condJumpValue;
    logic                         doRegJump;
    logic                         auiLink;
    logic                         isCall;
    logic                         isReturn;
    logic                         trapValid;
    logic [XLEN-1:0]              trapVector;
    logic [XLEN-1:0]              instructionAddress;
    logic [XLEN-1:0]              linkAddress;
    logic                         misaligned;
    logic [XLEN-1:0]              badAddress;
    logic                         rasMispredict;
    logic [$clog2(RAS_DEPTH):0]   rasCount;

    modport master (
        output enable, immJumpValue, regJumpValue, doForceJump, doCondJump, condJumpValue,
               doRegJump, auiLink, isCall, isReturn, trapValid, trapVector,
        input  instructionAddress, linkAddress, misaligned, badAddress, rasMispredict, rasCount
    );

    modport slave (
        input  enable, immJumpValue, regJumpValue, doForceJump, doCondJump, condJumpValue,
               doRegJump, auiLink, isCall, isReturn, trapValid, trapVector,
        output instructionAddress, linkAddress, misaligned, badAddress, rasMispredict, rasCount
    );
endinterface

// File: rtl/t04_pc_ras_unit.sv
// Program counter with trap redirect, JALR bit-0 clearing, misaligned-target rejection
// and a circular return-address stack that checks (but never steers) return targets.
module t04_pc_ras_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    t04_pc_ras_unit_if.slave  bus
);
    localparam int            PW   = $clog2(RAS_DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            mis_q, mis_d;
    logic            rmp_q, rmp_d;
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic            ras_we;
    logic [PW-1:0]   ras_waddr;

    logic [XLEN-1:0] pc_plus4, pc_plus_imm, reg_target, target;
    logic            taken, aligned, accept, push, pop;

    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc_plus_imm = pc_q + bus.immJumpValue;
    assign reg_target  = (bus.regJumpValue + bus.immJumpValue) & ~XLEN'(1);
    assign taken       = bus.doForceJump | (bus.doCondJump & bus.condJumpValue);

    always_comb begin
        target = pc_plus4;
        if (taken && bus.doRegJump && !bus.doCondJump) begin
            target = reg_target;
        end else if (taken) begin
            target = pc_plus_imm;
        end
    end

    assign aligned = (target[1:0] == 2'b00);
    assign accept  = bus.enable & ~bus.trapValid & aligned;
    assign push    = accept & taken & bus.isCall;
    assign pop     = accept & taken & bus.isReturn;

    always_comb begin
        pc_d      = pc_q;
        bad_d     = bad_q;
        mis_d     = 1'b0;
        rmp_d     = 1'b0;
        top_d     = top_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = top_q;
        if (bus.enable) begin
            if (bus.trapValid) begin
                pc_d = bus.trapVector;
            end else if (!aligned) begin
                mis_d = 1'b1;
                bad_d = target;
            end else begin
                pc_d = target;
                if (pop) begin
                    rmp_d = (cnt_q == '0) || (ras_q[top_q] != target);
                end
                // Call+return swaps the top entry in place; an empty stack gains its first entry.
                if (push && pop) begin
                    ras_we = 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d = CW'(1);
                    end
                end else if (push) begin
                    top_d     = top_q + PW'(1);
                    ras_waddr = top_q + PW'(1);
                    ras_we    = 1'b1;
                    cnt_d     = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
                end else if (pop && cnt_q != '0) begin
                    top_d = top_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            bad_q <= '0;
            mis_q <= 1'b0;
            rmp_q <= 1'b0;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            bad_q <= bad_d;
            mis_q <= mis_d;
            rmp_q <= rmp_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack contents are left unreset; only pointer and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && ras_we) begin
            ras_q[ras_waddr] <= pc_plus4;
        end
    end

    assign bus.linkAddress        = bus.doForceJump ? pc_plus4 :
                                    (bus.auiLink ? pc_plus_imm : '0);
    assign bus.instructionAddress = pc_q;
    assign bus.misaligned         = mis_q;
    assign bus.badAddress         = bad_q;
    assign bus.rasMispredict      = rmp_q;
    assign bus.rasCount           = cnt_q;
endmodule
